// File: rtl/autoconfig_pkg.sv
// Shared constants, size decoding and FSM encodings for the Zorro II autoconfig host.
package autoconfig_pkg;

  localparam logic [7:0] CFG_WIN     = 8'hE8;
  localparam logic [7:0] OFF_ID      = 8'h00;
  localparam logic [7:0] OFF_SIZE    = 8'h02;
  localparam logic [7:0] OFF_BASE_HI = 8'h48;
  localparam logic [7:0] OFF_BASE_LO = 8'h4A;
  localparam logic [7:0] OFF_SHUTUP  = 8'h4C;

  typedef enum logic [2:0] {
    SZ_8M   = 3'd0,
    SZ_64K  = 3'd1,
    SZ_128K = 3'd2,
    SZ_256K = 3'd3,
    SZ_512K = 3'd4,
    SZ_1M   = 3'd5,
    SZ_2M   = 3'd6,
    SZ_4M   = 3'd7
  } size_code_t;

  typedef logic [3:0] enum_state_t;

  localparam enum_state_t ST_IDLE  = 4'd0;
  localparam enum_state_t ST_RD00  = 4'd1;
  localparam enum_state_t ST_RD02  = 4'd2;
  localparam enum_state_t ST_ALLOC = 4'd3;
  localparam enum_state_t ST_WR4A  = 4'd4;
  localparam enum_state_t ST_WR48  = 4'd5;
  localparam enum_state_t ST_WR4C  = 4'd6;
  localparam enum_state_t ST_NEXT  = 4'd7;
  localparam enum_state_t ST_FIN   = 4'd8;

  // Board size in 64K units; code 0 is the 8MB case, the rest are powers of two.
  function automatic logic [8:0] size_units(input size_code_t code);
    if (code == SZ_8M) begin
      return 9'd128;
    end
    return 9'd1 << (code - 3'd1);
  endfunction

  // Word address (A23:1) of a byte offset inside the config window.
  function automatic logic [22:0] cfg_addr(input logic [7:0] off);
    return {CFG_WIN, 8'h00, off[7:1]};
  endfunction

endpackage

// File: rtl/zbus_cycle.sv
// Single Zorro II bus cycle master: strobes, _DTACK synchroniser and wait-state timeout.
module zbus_cycle #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        CLK,
  input  logic        _RST,
  input  logic        i_req,
  input  logic        i_rw,
  input  logic [22:0] i_addr,
  input  logic [3:0]  i_wdata,
  output logic        o_ack,
  output logic        o_timeout,
  output logic [3:0]  o_rdata,
  output logic [22:0] o_a,
  output logic [3:0]  o_d,
  output logic        o_d_oe,
  input  logic [3:0]  i_d,
  output logic        o_as_n,
  output logic        o_uds_n,
  output logic        o_rw,
  input  logic        i_dtack_n
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES);

  localparam logic [2:0] CY_IDLE = 3'd0;
  localparam logic [2:0] CY_C0   = 3'd1;
  localparam logic [2:0] CY_C1   = 3'd2;
  localparam logic [2:0] CY_C2   = 3'd3;
  localparam logic [2:0] CY_C3   = 3'd4;
  localparam logic [2:0] CY_C4   = 3'd5;

  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_to;
  logic          r_dt1, r_dt2;
  logic [3:0]    r_rdata;
  logic [22:0]   r_a;
  logic [3:0]    r_d;
  logic          r_d_oe, r_as_n, r_uds_n, r_rw;

  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      r_dt1 <= 1'b1;
      r_dt2 <= 1'b1;
    end else begin
      r_dt1 <= i_dtack_n;
      r_dt2 <= r_dt1;
    end
  end

  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      r_state <= CY_IDLE;
      r_cnt   <= '0;
      r_to    <= 1'b0;
      r_rdata <= 4'h0;
      r_a     <= '0;
      r_d     <= 4'h0;
      r_d_oe  <= 1'b0;
      r_as_n  <= 1'b1;
      r_uds_n <= 1'b1;
      r_rw    <= 1'b1;
    end else begin
      case (r_state)
        CY_IDLE: begin
          if (i_req) begin
            r_a     <= i_addr;
            r_rw    <= i_rw;
            r_d     <= i_wdata;
            r_d_oe  <= !i_rw;
            r_state <= CY_C0;
          end
        end
        CY_C0: begin
          r_as_n  <= 1'b0;
          r_state <= CY_C1;
        end
        CY_C1: begin
          r_uds_n <= 1'b0;
          r_cnt   <= '0;
          r_state <= CY_C2;
        end
        CY_C2: begin
          if (!r_dt2) begin
            r_rdata <= i_d;
            r_to    <= 1'b0;
            r_as_n  <= 1'b1;
            r_uds_n <= 1'b1;
            r_state <= CY_C3;
          end else if (r_cnt == TO_LAST) begin
            r_to    <= 1'b1;
            r_as_n  <= 1'b1;
            r_uds_n <= 1'b1;
            r_state <= CY_C3;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        CY_C3: begin
          r_d_oe  <= 1'b0;
          r_state <= CY_C4;
        end
        default: r_state <= CY_IDLE;
      endcase
    end
  end

  assign o_ack     = (r_state == CY_C4) && !r_to;
  assign o_timeout = (r_state == CY_C4) && r_to;
  assign o_rdata   = r_rdata;
  assign o_a       = r_a;
  assign o_d       = r_d;
  assign o_d_oe    = r_d_oe;
  assign o_as_n    = r_as_n;
  assign o_uds_n   = r_uds_n;
  assign o_rw      = r_rw;

endmodule

// File: rtl/autoconfig_host.sv
// Zorro II autoconfig enumerator: probes $E80000, places each board in RAM or I/O space
// at a naturally aligned base, and shuts up boards that do not fit.
module autoconfig_host
  import autoconfig_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned MAX_BOARDS     = 8,
  parameter logic [7:0]  RAM_LO         = 8'h20,
  parameter logic [7:0]  RAM_HI         = 8'hA0,
  parameter logic [7:0]  IO_LO          = 8'hE9,
  parameter logic [7:0]  IO_HI          = 8'hF0
) (
  input  logic        CLK,
  input  logic        _RST,
  input  logic        start,
  output logic [22:0] A,
  output logic [3:0]  D_o,
  output logic        d_oe,
  input  logic [3:0]  D_i,
  output logic        _AS,
  output logic        _UDS,
  output logic        RW,
  input  logic        _DTACK,
  output logic        _cfgout,
  output logic        busy,
  output logic        done,
  output logic [3:0]  board_count,
  output logic [3:0]  shut_count
);

  localparam logic [3:0] MAX_B = 4'(MAX_BOARDS);

  enum_state_t r_state;
  logic        r_issued;
  logic        r_memlist;
  size_code_t  r_size;
  logic [7:0]  r_base;
  logic [7:0]  r_ram_ptr, r_io_ptr;
  logic [3:0]  r_handled;
  logic        r_busy, r_done, r_cfgout;
  logic [3:0]  r_board_count, r_shut_count;

  logic        w_bus, w_req, w_rw, w_ack, w_timeout;
  logic [22:0] w_addr;
  logic [3:0]  w_wdata, w_rdata;
  logic [8:0]  w_units, w_ptr, w_hi, w_base, w_end;
  logic        w_io, w_fits;

  always_comb begin
    w_bus   = 1'b1;
    w_rw    = 1'b1;
    w_addr  = cfg_addr(OFF_ID);
    w_wdata = 4'h0;
    case (r_state)
      ST_RD00: w_addr = cfg_addr(OFF_ID);
      ST_RD02: w_addr = cfg_addr(OFF_SIZE);
      ST_WR4A: begin
        w_rw    = 1'b0;
        w_addr  = cfg_addr(OFF_BASE_LO);
        w_wdata = r_base[3:0];
      end
      ST_WR48: begin
        w_rw    = 1'b0;
        w_addr  = cfg_addr(OFF_BASE_HI);
        w_wdata = r_base[7:4];
      end
      ST_WR4C: begin
        w_rw   = 1'b0;
        w_addr = cfg_addr(OFF_SHUTUP);
      end
      default: w_bus = 1'b0;
    endcase
    w_req = w_bus && !r_issued;
  end

  // Small non-memlist boards go to I/O space; everything else competes for RAM space.
  always_comb begin
    w_units = size_units(r_size);
    w_io    = !r_memlist && (w_units <= 9'd8);
    w_ptr   = w_io ? {1'b0, r_io_ptr} : {1'b0, r_ram_ptr};
    w_hi    = w_io ? {1'b0, IO_HI}    : {1'b0, RAM_HI};
    w_base  = (w_ptr + w_units - 9'd1) & ~(w_units - 9'd1);
    w_end   = w_base + w_units;
    w_fits  = (w_end <= w_hi);
  end

  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      r_state       <= ST_IDLE;
      r_issued      <= 1'b0;
      r_memlist     <= 1'b0;
      r_size        <= SZ_8M;
      r_base        <= 8'h00;
      r_ram_ptr     <= RAM_LO;
      r_io_ptr      <= IO_LO;
      r_handled     <= 4'd0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_cfgout      <= 1'b1;
      r_board_count <= 4'd0;
      r_shut_count  <= 4'd0;
    end else begin
      r_done <= 1'b0;
      if (w_ack || w_timeout) begin
        r_issued <= 1'b0;
      end else if (w_req) begin
        r_issued <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_ram_ptr     <= RAM_LO;
            r_io_ptr      <= IO_LO;
            r_board_count <= 4'd0;
            r_shut_count  <= 4'd0;
            r_handled     <= 4'd0;
            r_busy        <= 1'b1;
            r_cfgout      <= 1'b0;
            r_state       <= ST_RD00;
          end
        end
        ST_RD00: begin
          if (w_timeout) begin
            r_state <= ST_FIN;
          end else if (w_ack) begin
            if (w_rdata[3:2] == 2'b11) begin
              r_memlist <= w_rdata[1];
              r_state   <= ST_RD02;
            end else begin
              r_state <= ST_FIN;
            end
          end
        end
        ST_RD02: begin
          if (w_timeout) begin
            r_state <= ST_FIN;
          end else if (w_ack) begin
            r_size  <= size_code_t'(w_rdata[2:0]);
            r_state <= ST_ALLOC;
          end
        end
        ST_ALLOC: begin
          if (w_fits) begin
            r_base <= w_base[7:0];
            if (w_io) begin
              r_io_ptr <= w_end[7:0];
            end else begin
              r_ram_ptr <= w_end[7:0];
            end
            r_state <= ST_WR4A;
          end else begin
            r_state <= ST_WR4C;
          end
        end
        ST_WR4A: begin
          if (w_timeout) begin
            r_state <= ST_FIN;
          end else if (w_ack) begin
            r_state <= ST_WR48;
          end
        end
        ST_WR48: begin
          if (w_timeout) begin
            r_state <= ST_FIN;
          end else if (w_ack) begin
            r_board_count <= r_board_count + 4'd1;
            r_handled     <= r_handled + 4'd1;
            r_state       <= ST_NEXT;
          end
        end
        ST_WR4C: begin
          if (w_timeout) begin
            r_state <= ST_FIN;
          end else if (w_ack) begin
            r_shut_count <= r_shut_count + 4'd1;
            r_handled    <= r_handled + 4'd1;
            r_state      <= ST_NEXT;
          end
        end
        ST_NEXT: r_state <= (r_handled < MAX_B) ? ST_RD00 : ST_FIN;
        ST_FIN: begin
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_cfgout <= 1'b1;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  zbus_cycle #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_cycle (
    .CLK      (CLK),
    ._RST     (_RST),
    .i_req    (w_req),
    .i_rw     (w_rw),
    .i_addr   (w_addr),
    .i_wdata  (w_wdata),
    .o_ack    (w_ack),
    .o_timeout(w_timeout),
    .o_rdata  (w_rdata),
    .o_a      (A),
    .o_d      (D_o),
    .o_d_oe   (d_oe),
    .i_d      (D_i),
    .o_as_n   (_AS),
    .o_uds_n  (_UDS),
    .o_rw     (RW),
    .i_dtack_n(_DTACK)
  );

  assign _cfgout     = r_cfgout;
  assign busy        = r_busy;
  assign done        = r_done;
  assign board_count = r_board_count;
  assign shut_count  = r_shut_count;

endmodule

// File: tb/tb_autoconfig_host.sv
// Scoreboard bench for autoconfig_host with a behavioural chain of autoconfig boards.
module tb_autoconfig_host;
  import autoconfig_pkg::*;

  logic        CLK = 1'b0;
  logic        _RST = 1'b0;
  logic        start = 1'b0;
  logic [22:0] A;
  logic [3:0]  D_o;
  logic        d_oe;
  logic [3:0]  D_i;
  logic        _AS, _UDS, RW, _DTACK, _cfgout, busy, done;
  logic [3:0]  board_count, shut_count;

  always #5 CLK = ~CLK;

  autoconfig_host dut (
    .CLK        (CLK),
    ._RST       (_RST),
    .start      (start),
    .A          (A),
    .D_o        (D_o),
    .d_oe       (d_oe),
    .D_i        (D_i),
    ._AS        (_AS),
    ._UDS       (_UDS),
    .RW         (RW),
    ._DTACK     (_DTACK),
    ._cfgout    (_cfgout),
    .busy       (busy),
    .done       (done),
    .board_count(board_count),
    .shut_count (shut_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- board chain model ----------------
  logic [3:0] b_n0[8];
  logic [3:0] b_n2[8];
  int         nb = 0;
  bit         stall48 = 1'b0;
  bit         brd_clr = 1'b0;
  int         n_done;
  logic       r_dtack;
  logic       act_ok;

  assign _DTACK = r_dtack;
  assign act_ok = !_cfgout && (n_done < nb);

  always_comb begin
    D_i = 4'hF;
    if (act_ok) begin
      if (A[6:0] == 7'h00) D_i = b_n0[n_done];
      else if (A[6:0] == 7'h01) D_i = b_n2[n_done];
    end
  end

  always @(posedge CLK) begin
    if (brd_clr) begin
      n_done  <= 0;
      r_dtack <= 1'b1;
    end else if (_AS) begin
      r_dtack <= 1'b1;
    end else if (!_UDS && r_dtack && act_ok && !(stall48 && !RW && A[6:0] == 7'h24)) begin
      r_dtack <= 1'b0;
      if (!RW && (A[6:0] == 7'h24 || A[6:0] == 7'h26)) n_done <= n_done + 1;
    end
  end

  task automatic brd_reset();
    brd_clr = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    brd_clr = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    bit         is_done;
    bit         rw;
    logic [7:0] off;
    logic [3:0] data;
    logic [3:0] bc;
    logic [3:0] sc;
  } exp_t;

  exp_t q[$];

  task automatic exp_rd(input logic [7:0] off);
    q.push_back('{is_done: 1'b0, rw: 1'b1, off: off, data: 4'h0, bc: 4'h0, sc: 4'h0});
  endtask

  task automatic exp_wr(input logic [7:0] off, input logic [3:0] data);
    q.push_back('{is_done: 1'b0, rw: 1'b0, off: off, data: data, bc: 4'h0, sc: 4'h0});
  endtask

  task automatic exp_done(input logic [3:0] bc, input logic [3:0] sc);
    q.push_back('{is_done: 1'b1, rw: 1'b1, off: 8'h00, data: 4'h0, bc: bc, sc: sc});
  endtask

  logic prev_uds = 1'b1;
  int   as_low_cnt = 0;

  always @(negedge CLK) begin
    exp_t e;
    if (!_AS) as_low_cnt++;
    if (prev_uds && !_UDS) begin
      if (q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_cycle: A=%h RW=%b, expected nothing", A, RW);
      end else begin
        e = q.pop_front();
        if (e.is_done) begin
          n_tests++; n_fail++;
          $display("FAIL order: got bus cycle A=%h, expected done", A);
        end else begin
          check("cycle_addr", 32'(A), 32'(cfg_addr(e.off)));
          check("cycle_rw", 32'(RW), 32'(e.rw));
          if (!e.rw) begin
            check("cycle_wdata", 32'(D_o), 32'(e.data));
            check("cycle_doe", 32'(d_oe), 32'd1);
          end
        end
      end
    end
    if (done) begin
      if (q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_done: got done, expected nothing");
      end else begin
        e = q.pop_front();
        if (!e.is_done) begin
          n_tests++; n_fail++;
          $display("FAIL order: got done, expected cycle at offset %h", e.off);
        end else begin
          check("board_count", 32'(board_count), 32'(e.bc));
          check("shut_count", 32'(shut_count), 32'(e.sc));
          check("strobes_idle", 32'({_AS, _UDS}), 32'b11);
          check("busy_at_done", 32'(busy), 32'd0);
        end
      end
    end
    prev_uds = _UDS;
  end

  task automatic run_enum(input string name, input bit poke);
    bit seen = 1'b0;
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (poke && k == 20) start = 1'b1;
      else start = 1'b0;
      @(negedge CLK);
    end
    start = 1'b0;
    if (!seen) begin
      n_tests++; n_fail++;
      $display("FAIL %s_done_timeout: got no done, expected done", name);
    end
    @(negedge CLK);
    check({name, "_queue_left"}, 32'(q.size()), 32'd0);
    q.delete();
  endtask

  initial begin
    int as0;
    bit hit;
    brd_clr = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_A", 32'(A), 32'd0);
    check("rst_D_o", 32'(D_o), 32'd0);
    check("rst_d_oe", 32'(d_oe), 32'd0);
    check("rst_strobes", 32'({_AS, _UDS, RW}), 32'b111);
    check("rst_cfgout", 32'(_cfgout), 32'd1);
    check("rst_busy_done", 32'({busy, done}), 32'd0);
    check("rst_counts", 32'({board_count, shut_count}), 32'd0);
    _RST = 1'b1;
    brd_clr = 1'b0;

    // One 2MB board at $200000
    nb = 1; b_n0[0] = 4'b1110; b_n2[0] = 4'b0110;
    brd_reset();
    exp_rd(8'h00); exp_rd(8'h02); exp_wr(8'h4A, 4'h0); exp_wr(8'h48, 4'h2);
    exp_rd(8'h00); exp_done(4'd1, 4'd0);
    run_enum("one_2mb", 1'b0);

    // 2MB then 4MB: second lands at $400000
    nb = 2; b_n0[0] = 4'b1110; b_n2[0] = 4'b0110; b_n0[1] = 4'b1110; b_n2[1] = 4'b0111;
    brd_reset();
    exp_rd(8'h00); exp_rd(8'h02); exp_wr(8'h4A, 4'h0); exp_wr(8'h48, 4'h2);
    exp_rd(8'h00); exp_rd(8'h02); exp_wr(8'h4A, 4'h0); exp_wr(8'h48, 4'h4);
    exp_rd(8'h00); exp_done(4'd2, 4'd0);
    run_enum("two_ram", 1'b0);
    check("ram_ptr", 32'(dut.r_ram_ptr), 32'h80);

    // 8MB board never fits and is shut up
    nb = 1; b_n0[0] = 4'b1110; b_n2[0] = 4'b0000;
    brd_reset();
    exp_rd(8'h00); exp_rd(8'h02); exp_wr(8'h4C, 4'h0);
    exp_rd(8'h00); exp_done(4'd0, 4'd1);
    run_enum("shutup_8mb", 1'b0);

    // Empty bus: single timed-out probe, _AS held for 64 wait cycles plus 2
    nb = 0;
    brd_reset();
    as0 = as_low_cnt;
    exp_rd(8'h00); exp_done(4'd0, 4'd0);
    run_enum("empty", 1'b0);
    check("timeout_as_low", 32'(as_low_cnt - as0), 32'd66);

    // Two 64K I/O boards; a stray start mid-run must be ignored
    nb = 2; b_n0[0] = 4'b1100; b_n2[0] = 4'b1001; b_n0[1] = 4'b1100; b_n2[1] = 4'b1001;
    brd_reset();
    exp_rd(8'h00); exp_rd(8'h02); exp_wr(8'h4A, 4'h9); exp_wr(8'h48, 4'hE);
    exp_rd(8'h00); exp_rd(8'h02); exp_wr(8'h4A, 4'hA); exp_wr(8'h48, 4'hE);
    exp_rd(8'h00); exp_done(4'd2, 4'd0);
    run_enum("two_io", 1'b1);

    // Reset while WR48 is stalled waiting for _DTACK
    nb = 1; b_n0[0] = 4'b1110; b_n2[0] = 4'b0110; stall48 = 1'b1;
    brd_reset();
    exp_rd(8'h00); exp_rd(8'h02); exp_wr(8'h4A, 4'h0); exp_wr(8'h48, 4'h2);
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 500; k++) begin
      if (!_UDS && !RW && A[6:0] == 7'h24) begin
        hit = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    check("wr48_reached", 32'(hit), 32'd1);
    repeat (10) @(negedge CLK);
    check("wr48_still_waiting", 32'({_AS, _UDS, d_oe}), 32'b001);
    #2 _RST = 1'b0;
    #1;
    check("midrst_strobes", 32'({_AS, _UDS}), 32'b11);
    check("midrst_d_oe", 32'(d_oe), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_board_count", 32'(board_count), 32'd0);
    check("midrst_queue_left", 32'(q.size()), 32'd0);
    q.delete();
    @(negedge CLK);
    stall48 = 1'b0;
    _RST = 1'b1;
    repeat (2) @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
